// File: rtl/tex_mem_pkg.sv
// Shared helpers for the texture memory response path.
// Tags carry {upstream tag, source index} with the index in the LSBs.
package tex_mem_pkg;

    function automatic int log_num_reqs(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Index width never drops to zero so a single-input build still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tex_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the pointer upward with wrap.
// The pointer moves past the winner only when advance is set.
module tex_rr_arbiter
    import tex_mem_pkg::*;
#(
    parameter  int NUM_REQS = 4,
    localparam int IDX_W    = idx_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            if (grant_idx == IDX_W'(NUM_REQS - 1))
                ptr <= '0;
            else
                ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/tex_mem_rsp_arb.sv
// Merges NUM_REQS memory response streams into one registered stream,
// appending the source index to the tag for the downstream demux.
module tex_mem_rsp_arb
    import tex_mem_pkg::*;
#(
    parameter  int NUM_REQS      = 4,
    parameter  int DATA_WIDTH    = 32,
    parameter  int TAG_WIDTH     = 8,
    localparam int LOG_NUM_REQS  = log_num_reqs(NUM_REQS),
    localparam int TAG_OUT_WIDTH = TAG_WIDTH + LOG_NUM_REQS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            rsp_in_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_in_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]  rsp_in_tag,
    output logic [NUM_REQS-1:0]            rsp_in_ready,
    output logic                           rsp_out_valid,
    output logic [DATA_WIDTH-1:0]          rsp_out_data,
    output logic [TAG_OUT_WIDTH-1:0]       rsp_out_tag,
    input  logic                           rsp_out_ready
);

    localparam int IDX_W = idx_width(NUM_REQS);

    logic [NUM_REQS-1:0]      grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     can_load;
    logic                     xfer;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [TAG_WIDTH-1:0]     sel_tag;
    logic [TAG_OUT_WIDTH-1:0] sel_tag_out;

    tex_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (rsp_in_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Downstream ready feeds straight through to the granted input.
    assign can_load     = !rsp_out_valid || rsp_out_ready;
    assign rsp_in_ready = reset ? '0 : (grant & {NUM_REQS{can_load}});
    assign xfer         = |(rsp_in_valid & rsp_in_ready);

    assign sel_data = rsp_in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tag  = rsp_in_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];

    generate
        if (LOG_NUM_REQS == 0) begin : g_single
            assign sel_tag_out = sel_tag;
        end else begin : g_multi
            assign sel_tag_out = {sel_tag, grant_idx[LOG_NUM_REQS-1:0]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_out_valid <= 1'b0;
            rsp_out_data  <= '0;
            rsp_out_tag   <= '0;
        end else if (xfer) begin
            rsp_out_valid <= 1'b1;
            rsp_out_data  <= sel_data;
            rsp_out_tag   <= sel_tag_out;
        end else if (rsp_out_ready) begin
            rsp_out_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) assert ($onehot0(grant)) else $error("grant not one-hot");
    end

    assert property (@(posedge clk) disable iff (reset)
        (rsp_out_valid && !rsp_out_ready) |=>
        (rsp_out_valid && $stable(rsp_out_data) && $stable(rsp_out_tag)))
        else $error("output changed while stalled");
`endif

endmodule

// File: tb/tb_tex_mem_rsp_arb.sv
// Scoreboard bench for tex_mem_rsp_arb: a round-robin reference model
// predicts grants and beats; a monitor checks every drained output beat.
module tb_tex_mem_rsp_arb;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int TOW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    rsp_in_valid;
    logic [N*DW-1:0] rsp_in_data;
    logic [N*TW-1:0] rsp_in_tag;
    logic [N-1:0]    rsp_in_ready;
    logic            rsp_out_valid;
    logic [DW-1:0]   rsp_out_data;
    logic [TOW-1:0]  rsp_out_tag;
    logic            rsp_out_ready;

    always #5 clk = ~clk;

    tex_mem_rsp_arb #(
        .NUM_REQS   (N),
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rsp_in_valid  (rsp_in_valid),
        .rsp_in_data   (rsp_in_data),
        .rsp_in_tag    (rsp_in_tag),
        .rsp_in_ready  (rsp_in_ready),
        .rsp_out_valid (rsp_out_valid),
        .rsp_out_data  (rsp_out_data),
        .rsp_out_tag   (rsp_out_tag),
        .rsp_out_ready (rsp_out_ready)
    );

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [TOW-1:0] tag;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    checks = 0;
    int    fails  = 0;
    int    m_ptr  = 0;
    bit    m_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int i, input bit v, input logic [DW-1:0] d,
                          input logic [TW-1:0] t);
        rsp_in_valid[i]        = v;
        rsp_in_data[i*DW +: DW] = d;
        rsp_in_tag[i*TW +: TW]  = t;
    endtask

    task automatic clear_in();
        for (int i = 0; i < N; i++) set_in(i, 1'b0, $urandom, 8'($urandom));
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cycle();
        int           g;
        bit           can_load;
        logic [N-1:0] exp_rdy;
        beat_t        b;
        #1;
        can_load = !m_valid || rsp_out_ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int jj = (m_ptr + k) % N;
            if (g < 0 && rsp_in_valid[jj]) g = jj;
        end
        exp_rdy = '0;
        if (!reset && can_load && g >= 0) exp_rdy[g] = 1'b1;
        check("rsp_in_ready", 64'(rsp_in_ready), 64'(exp_rdy));
        check("rsp_out_valid", 64'(rsp_out_valid), 64'(m_valid));
        b = '0;
        if (exp_rdy != '0) begin
            b.data = rsp_in_data[g*DW +: DW];
            b.tag  = TOW'(int'(rsp_in_tag[g*TW +: TW]) * N + g);
        end
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            sb.delete();
        end else if (exp_rdy != '0) begin
            sb.push_back(b);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (rsp_out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && rsp_out_valid && rsp_out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_beat: got tag %0h expected none", rsp_out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_out_data", 64'(rsp_out_data), 64'(mon_e.data));
                    check("rsp_out_tag", 64'(rsp_out_tag), 64'(mon_e.tag));
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        rsp_out_ready = 1'b1;
        rsp_in_valid  = '0;
        rsp_in_data   = '0;
        rsp_in_tag    = '0;
        @(negedge clk);
        repeat (3) cycle();
        reset = 1'b0;
        repeat (2) cycle();

        // single beat on input 2
        set_in(2, 1'b1, 32'hDEADBEEF, 8'h5A);
        cycle();
        clear_in();
        #1;
        check("directed_data", 64'(rsp_out_data), 64'h0000_0000_DEAD_BEEF);
        check("directed_tag", 64'(rsp_out_tag), 64'h16A);
        cycle();
        cycle();

        // all inputs held valid, no bubbles
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_in(i, 1'b1, $urandom, 8'($urandom));
            cycle();
        end

        // output stall with beat from input 1
        clear_in();
        set_in(1, 1'b1, 32'h1111_0001, 8'h11);
        cycle();
        rsp_out_ready = 1'b0;
        clear_in();
        set_in(0, 1'b1, 32'h0000_0A0A, 8'h0A);
        set_in(2, 1'b1, 32'h2222_0002, 8'h22);
        repeat (5) cycle();
        rsp_out_ready = 1'b1;
        cycle();
        clear_in();
        repeat (2) cycle();

        // inputs 0 and 3 from pointer 1
        set_in(0, 1'b1, 32'h0, 8'h01);
        cycle();
        clear_in();
        for (int c = 0; c < 4; c++) begin
            set_in(0, 1'b1, $urandom, 8'($urandom));
            set_in(3, 1'b1, $urandom, 8'($urandom));
            cycle();
        end
        clear_in();
        repeat (2) cycle();

        // reset while a beat is stalled
        set_in(2, 1'b1, 32'hCAFE_0002, 8'h33);
        cycle();
        rsp_out_ready = 1'b0;
        clear_in();
        cycle();
        reset = 1'b1;
        set_in(1, 1'b1, 32'hB0B0_0001, 8'h44);
        set_in(3, 1'b1, 32'hB0B0_0003, 8'h55);
        cycle();
        reset = 1'b0;
        rsp_out_ready = 1'b1;
        cycle();
        clear_in();
        repeat (2) cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++)
                set_in(i, ($urandom_range(0, 9) < 6), $urandom, 8'($urandom));
            rsp_out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        reset = 1'b0;
        rsp_out_ready = 1'b1;
        clear_in();
        repeat (3) cycle();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tex_mem_rsp_arb.md
Name: tex_mem_rsp_arb

Overview:
- Merges NUM_REQS independent memory-response streams (valid/data/tag/ready, slave side) into one response stream (master side) toward the texture unit.
- Round-robin arbitration with one registered output stage.
- Source index is appended to the tag so the downstream demux can route responses back.
- Sits between the per-bank/per-port response channels and the single texture-unit response consumer.

Parameters:
- NUM_REQS, 4, number of input response streams (>=1).
- DATA_WIDTH, 32, response data width.
- TAG_WIDTH, 8, input tag width.
- LOG_NUM_REQS, derived: clog2(NUM_REQS), or 0 when NUM_REQS==1; not overridable.
- TAG_OUT_WIDTH, derived: TAG_WIDTH + LOG_NUM_REQS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rsp_in_valid  in  NUM_REQS  per-input valid
- rsp_in_data  in  NUM_REQS*DATA_WIDTH  per-input data; input i at slice [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_in_tag  in  NUM_REQS*TAG_WIDTH  per-input tag, same slicing
- rsp_in_ready  out  NUM_REQS  per-input ready
- rsp_out_valid  out  1  merged valid
- rsp_out_data  out  DATA_WIDTH  merged data
- rsp_out_tag  out  TAG_OUT_WIDTH  {input tag, source index}; index in the LSBs
- rsp_out_ready  in  1  downstream ready

Behaviour:
- Interface: one clock (clk). Reset (reset) is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - rsp_out_valid=0; rsp_out_data and rsp_out_tag = 0.
  - Priority pointer = 0.
  - rsp_in_ready = 0 while reset is asserted.
- Output register (single entry): `can_load = !rsp_out_valid || rsp_out_ready`.
- Arbitration (combinational, each cycle):
  - Scan inputs starting at the pointer, ascending with wrap-around.
  - The first input with valid=1 gets grant (one-hot).
  - No valid inputs: grant = 0.
- Handshakes:
  - rsp_in_ready[i] = grant[i] && can_load. Ready is therefore never asserted to a non-granted input.
  - Transfer on input i when rsp_in_valid[i] && rsp_in_ready[i]. At that edge:
    - output register <= {data_i, tag_i, i};
    - rsp_out_valid <= 1;
    - pointer <= (i+1) mod NUM_REQS.
  - Output drained (rsp_out_valid && rsp_out_ready) with no new transfer: rsp_out_valid <= 0.
  - Simultaneous drain and load in the same cycle: the new beat replaces the old one. Sustained throughput is 1 beat/cycle.
  - The pointer changes only on a transfer. An idle cycle or a stalled output keeps the pointer.
- Latency: input transfer at edge N; data visible on rsp_out_* from edge N (one registered cycle).
- Backpressure:
  - rsp_out_ready=0 with rsp_out_valid=1 holds rsp_out_* stable.
  - All rsp_in_ready stay 0 until the drain.
- Combinational path rsp_out_ready -> rsp_in_ready is permitted and intended.
- Ordering: per-input order is preserved. No ordering guarantee across inputs.
- Fairness: any input held valid is granted within NUM_REQS transfers.
- NUM_REQS==1: pass-through register. No index bits; TAG_OUT_WIDTH = TAG_WIDTH.
- Reset mid-operation: a held beat is dropped, rsp_out_valid=0 the next cycle, pointer returns to 0. The upstream side must reissue.
- Input data/tag are ignored when valid=0. Input valid need not be held stable; dropping valid before ready is tolerated.
- Assertions (sim only):
  - grant is one-hot-or-zero.
  - rsp_out_* are stable while valid && !ready.

Decomposition:
- Shared package tex_mem_pkg: clog2-based LOG_NUM_REQS helper and the tag packing/unpacking convention (index in LSBs). The matching response demux reuses it.
- One sub-module: tex_rr_arbiter (NUM_REQS; inputs requests + advance enable; outputs one-hot grant + encoded index; owns the pointer register).

Test Plan:
- Reset then idle, all inputs valid=0 -> rsp_out_valid=0, rsp_in_ready=0000, pointer=0.
- Single beat on input 2 (data=0xDEADBEEF, tag=0x5A), rsp_out_ready=1 -> next cycle rsp_out_valid=1, data=0xDEADBEEF, tag=0x5A<<2|2=0x16A; following cycle valid=0.
- All four inputs held valid, rsp_out_ready=1 -> grants 0,1,2,3,0,... one per cycle; output index sequence 0,1,2,3 with no bubbles.
- Output stall: beat from input 1 held with rsp_out_ready=0 for 5 cycles -> rsp_out_* stable; all rsp_in_ready=0; pointer stays 2; on release, input 2 (if valid) is granted in the same cycle.
- Inputs 0 and 3 valid, pointer=1 -> input 3 granted first, then 0, then 3; inputs 1 and 2 never see ready.
- Reset asserted while rsp_out_valid=1, rsp_out_ready=0 -> next cycle rsp_out_valid=0, pointer=0; first post-reset grant goes to the lowest valid index.
